// File: rtl/toggle_monitor.sv
// Observer for a T flip-flop stage: q edge pulses, saturating edge count and rise-to-rise period.
// Define TOGGLE_MON_COMP_CHECK_EN to enable the sticky qb/q complement check on comp_err.
module toggle_monitor #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             q_in,
    input  logic             qb_in,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             period_ovf,
    output logic             comp_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

    logic             q_dly_q;
    logic             rise_s;
    logic             fall_s;
    logic [CNT_W-1:0] edge_cnt_d;
    logic             cnt_sat_d;
    logic [PER_W-1:0] per_cnt_q;
    state_t           state_q;

    assign rise_s = q_in & ~q_dly_q;
    assign fall_s = ~q_in & q_dly_q;

    // q history; deliberately immune to clr so clearing never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_dly_q <= 1'b0;
        end else begin
            q_dly_q <= q_in;
        end
    end

    // Next-state of the saturating edge counter and its sticky flag
    always_comb begin
        edge_cnt_d = edge_cnt;
        cnt_sat_d  = cnt_sat;
        if (clr) begin
            edge_cnt_d = {CNT_W{1'b0}};
            cnt_sat_d  = 1'b0;
        end else if ((rise_s | fall_s) && (edge_cnt != CNT_MAX)) begin
            edge_cnt_d = edge_cnt + CNT_ONE;
            cnt_sat_d  = cnt_sat | (edge_cnt_d == CNT_MAX);
        end else begin
            edge_cnt_d = edge_cnt;
            cnt_sat_d  = cnt_sat | (edge_cnt == CNT_MAX);
        end
    end

    // Edge pulses and edge counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= {CNT_W{1'b0}};
            cnt_sat  <= 1'b0;
        end else begin
            rise     <= rise_s & ~clr;
            fall     <= fall_s & ~clr;
            edge_cnt <= edge_cnt_d;
            cnt_sat  <= cnt_sat_d;
        end
    end

    // Period FSM: the first rise only arms, later rises report the cycles since the previous rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= {PER_W{1'b0}};
            period     <= {PER_W{1'b0}};
            period_vld <= 1'b0;
            period_ovf <= 1'b0;
        end else if (clr) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= {PER_W{1'b0}};
            period     <= {PER_W{1'b0}};
            period_vld <= 1'b0;
            period_ovf <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    period_vld <= 1'b0;
                    if (rise_s) begin
                        state_q   <= ST_ARMED;
                        per_cnt_q <= PER_ONE;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (rise_s) begin
                        period     <= per_cnt_q;
                        period_vld <= 1'b1;
                        per_cnt_q  <= PER_ONE;
                        if (per_cnt_q == PER_MAX) begin
                            period_ovf <= 1'b1;
                        end else begin
                            period_ovf <= period_ovf;
                        end
                    end else begin
                        period_vld <= 1'b0;
                        if (per_cnt_q != PER_MAX) begin
                            per_cnt_q <= per_cnt_q + PER_ONE;
                        end else begin
                            per_cnt_q <= per_cnt_q;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    per_cnt_q  <= {PER_W{1'b0}};
                    period_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef TOGGLE_MON_COMP_CHECK_EN
    logic chk_arm_q;

    // Complement check, armed one cycle after reset release so the first edge is skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_arm_q <= 1'b0;
            comp_err  <= 1'b0;
        end else begin
            chk_arm_q <= 1'b1;
            if (clr) begin
                comp_err <= 1'b0;
            end else if (chk_arm_q && (qb_in == q_in)) begin
                comp_err <= 1'b1;
            end else begin
                comp_err <= comp_err;
            end
        end
    end
`else
    logic unused_qb_s;
    assign unused_qb_s = qb_in;
    assign comp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed self-checking bench for toggle_monitor (CNT_W=4, PER_W=8).
module tb_toggle_monitor;

    localparam int CNT_W = 4;
    localparam int PER_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             q_in;
    logic             qb_in;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] edge_cnt;
    logic             cnt_sat;
    logic [PER_W-1:0] period;
    logic             period_vld;
    logic             period_ovf;
    logic             comp_err;

    int n_assert = 0;
    int n_fail   = 0;
    int vld_seen = 0;

    toggle_monitor #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .q_in(q_in), .qb_in(qb_in),
        .rise(rise), .fall(fall), .edge_cnt(edge_cnt), .cnt_sat(cnt_sat),
        .period(period), .period_vld(period_vld), .period_ovf(period_ovf),
        .comp_err(comp_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input logic v);
        q_in  = v;
        qb_in = ~v;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {16'd0, rise, fall, edge_cnt, cnt_sat, period, period_vld, period_ovf, comp_err},
              32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        set_q(1'b0);
        #25;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // 1) idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all_zero("idle");
        end

        // 2) toggle every 2 clks, 10 toggles
        for (int i = 0; i < 10; i++) begin
            set_q(~q_in);
            tick();
            check("t2_rise", {31'd0, rise}, {31'd0, q_in});
            check("t2_fall", {31'd0, fall}, {31'd0, ~q_in});
            check("t2_edge_cnt", {28'd0, edge_cnt}, i + 1);
            check("t2_vld", {31'd0, period_vld}, {31'd0, (q_in && i > 0)});
            if (period_vld) begin
                vld_seen++;
                check("t2_period", {24'd0, period}, 32'd4);
            end
            tick();
            check("t2_pulse_gone", {30'd0, rise, fall}, 32'd0);
        end
        check("t2_vld_count", vld_seen, 32'd4);
        check("t2_ovf", {31'd0, period_ovf}, 32'd0);

        // 3) period saturation
        set_q(1'b1);
        tick();
        check("t3_vld", {31'd0, period_vld}, 32'd1);
        check("t3_period4", {24'd0, period}, 32'd4);
        repeat (300) tick();
        set_q(1'b0);
        tick();
        set_q(1'b1);
        tick();
        check("t3_vld_sat", {31'd0, period_vld}, 32'd1);
        check("t3_period_sat", {24'd0, period}, 32'd255);
        check("t3_ovf", {31'd0, period_ovf}, 32'd1);
        check("t3_edge_cnt", {28'd0, edge_cnt}, 32'd13);
        check("t3_cnt_sat", {31'd0, cnt_sat}, 32'd0);

        // 4) clr, then 20 edges into a 4-bit counter
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_cnt", {28'd0, edge_cnt}, 32'd0);
        check("t4_clr_ovf", {31'd0, period_ovf}, 32'd0);
        check("t4_clr_period", {24'd0, period}, 32'd0);
        tick();
        check("t4_no_spurious", {30'd0, rise, fall}, 32'd0);
        for (int j = 0; j < 20; j++) begin
            set_q(~q_in);
            tick();
            check("t4_edge_cnt", {28'd0, edge_cnt}, (j + 1 > 15) ? 32'd15 : j + 1);
            check("t4_vld", {31'd0, period_vld}, {31'd0, (q_in && j > 1)});
            if (period_vld) check("t4_period", {24'd0, period}, 32'd2);
        end
        check("t4_cnt_sat", {31'd0, cnt_sat}, 32'd1);
        clr = 1'b1;
        set_q(~q_in);
        tick();
        clr = 1'b0;
        check("t4_clr_wins", {27'd0, rise, fall, edge_cnt}, 32'd0);
        check("t4_clr_sat", {31'd0, cnt_sat}, 32'd0);
        tick();
        check("t4_after_clr", {27'd0, rise, fall, edge_cnt}, 32'd0);

        // 5) complement check
        qb_in = q_in;
        tick();
        qb_in = ~q_in;
`ifdef TOGGLE_MON_COMP_CHECK_EN
        check("t5_comp_err", {31'd0, comp_err}, 32'd1);
        tick();
        check("t5_comp_sticky", {31'd0, comp_err}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_comp_clr", {31'd0, comp_err}, 32'd0);
`else
        check("t5_comp_err", {31'd0, comp_err}, 32'd0);
        tick();
        check("t5_comp_sticky", {31'd0, comp_err}, 32'd0);
`endif

        // 6) async reset mid-count
        for (int k = 0; k < 6; k++) begin
            set_q(~q_in);
            tick();
        end
        check("t6_edge_cnt", {28'd0, edge_cnt}, 32'd6);
        #5;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        set_q(1'b1);
        #4;
        rst_n = 1'b1;
        tick();
        check("t6_first_rise", {31'd0, rise}, 32'd1);
        check("t6_restart_cnt", {28'd0, edge_cnt}, 32'd1);
        check("t6_no_vld", {31'd0, period_vld}, 32'd0);
        check("t6_comp_err", {31'd0, comp_err}, 32'd0);
        tick();
        check("t6_rise_gone", {31'd0, rise}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
